// File: rtl/div_clk_meter_if.sv
// Measurement bundle between the divided-clock source and the divided-clock meter.
// The source side is the master and the meter side is the slave.
`timescale 1ns/1ps
interface div_clk_meter_if #(
    parameter int CNT_W = 8
);
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             period_err;
    logic             duty_err;
    logic             stuck;
    logic             lock;
    logic [7:0]       err_cnt;

    modport master (
        output clk_in,
        input  period, high_time, meas_valid, period_err, duty_err, stuck, lock, err_cnt
    );

    modport slave (
        input  clk_in,
        output period, high_time, meas_valid, period_err, duty_err, stuck, lock, err_cnt
    );
endinterface

// File: rtl/div_clk_meter.sv
// Measures period and high time of the divided clock in system-clock cycles,
// flags period/duty/stuck faults and reports lock after a run of good periods.
`timescale 1ns/1ps
module div_clk_meter #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int HIGH_MIN   = 2,
    parameter int HIGH_MAX   = 3,
    parameter int TIMEOUT    = 64,
    parameter int LOCK_N     = 4
) (
    input  logic          clk,
    input  logic          rst,
    div_clk_meter_if.slave mon
);
    localparam int GR_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] H_MIN  = CNT_W'(HIGH_MIN);
    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [GR_W-1:0]  LOCK_G = GR_W'(LOCK_N);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             period_err_q, period_err_d;
    logic             duty_err_q, duty_err_d;
    logic             stuck_q, stuck_d;
    logic             lock_q, lock_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;

    logic             rise;
    logic             p_bad;
    logic             h_bad;
    logic [7:0]       err_inc;

    assign rise    = s1_q & ~s2_q;
    assign p_bad   = (cnt_p_q != EXP_P);
    assign h_bad   = (cnt_h_q < H_MIN) || (cnt_h_q > H_MAX);
    assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // A rise always wins over a timeout on the same cycle, so a period of
    // exactly TIMEOUT cycles is still reported as a measurement.
    always_comb begin
        s1_d         = mon.clk_in;
        s2_d         = s1_q;
        state_d      = state_q;
        cnt_p_d      = cnt_p_q;
        cnt_h_d      = cnt_h_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        period_err_d = period_err_q;
        duty_err_d   = duty_err_q;
        stuck_d      = stuck_q;
        lock_d       = lock_q;
        err_cnt_d    = err_cnt_q;
        good_run_d   = good_run_q;

        case (state_q)
            IDLE: begin
                cnt_p_d = '0;
                cnt_h_d = '0;
                if (rise) begin
                    state_d = RUN;
                    cnt_p_d = ONE;
                    cnt_h_d = ONE;
                    stuck_d = 1'b0;
                end
            end
            RUN: begin
                if (rise) begin
                    period_d     = cnt_p_q;
                    high_time_d  = cnt_h_q;
                    meas_valid_d = 1'b1;
                    period_err_d = p_bad;
                    duty_err_d   = h_bad;
                    cnt_p_d      = ONE;
                    cnt_h_d      = ONE;
                    if (p_bad || h_bad) begin
                        good_run_d = '0;
                        lock_d     = 1'b0;
                        err_cnt_d  = err_inc;
                    end else begin
                        if (good_run_q != LOCK_G) begin
                            good_run_d = good_run_q + GR_W'(1);
                        end
                        lock_d = (good_run_d == LOCK_G);
                    end
                end else if (cnt_p_q == TMO) begin
                    state_d    = IDLE;
                    stuck_d    = 1'b1;
                    good_run_d = '0;
                    lock_d     = 1'b0;
                    err_cnt_d  = err_inc;
                    cnt_p_d    = '0;
                    cnt_h_d    = '0;
                end else begin
                    cnt_p_d = cnt_p_q + ONE;
                    if (s1_q) begin
                        cnt_h_d = cnt_h_q + ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            cnt_p_q      <= '0;
            cnt_h_q      <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            duty_err_q   <= 1'b0;
            stuck_q      <= 1'b0;
            lock_q       <= 1'b0;
            err_cnt_q    <= '0;
            good_run_q   <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cnt_p_q      <= cnt_p_d;
            cnt_h_q      <= cnt_h_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            period_err_q <= period_err_d;
            duty_err_q   <= duty_err_d;
            stuck_q      <= stuck_d;
            lock_q       <= lock_d;
            err_cnt_q    <= err_cnt_d;
            good_run_q   <= good_run_d;
        end
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_time_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.period_err = period_err_q;
    assign mon.duty_err   = duty_err_q;
    assign mon.stuck      = stuck_q;
    assign mon.lock       = lock_q;
    assign mon.err_cnt    = err_cnt_q;

endmodule
